// File: rtl/fetch_stage.sv
// fetch_stage: PC, DEPTH-word instruction memory and IF/ID register for the 5-stage core.
// A boot loader fills imem in LOAD, then RUN fetches; define FETCH_PERF_EN for perf counters.
module fetch_stage #(
  parameter int unsigned AWL   = 6,
  parameter int unsigned DWL   = 32,
  parameter int unsigned DEPTH = 2 ** AWL
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           LdValid,
  input  logic [DWL-1:0] LdData,
  input  logic           LdLast,
  output logic           LdReady,
  output logic           Running,
  input  logic           Stall,
  input  logic           JumpD,
  input  logic [DWL-1:0] PCJumpD,
  input  logic           PCSelD,
  input  logic [DWL-1:0] PCBranchD,
  output logic [DWL-1:0] PCF,
  output logic [DWL-1:0] InstrD,
  output logic [DWL-1:0] PCp1D,
  output logic           ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [DWL-1:0] StallCnt,
  output logic [DWL-1:0] FlushCnt
`endif
);

  typedef enum logic [0:0] {StLoad, StRun} stateT;

  stateT          state;
  logic [AWL-1:0] ldPtr;
  logic [DWL-1:0] imem [DEPTH];
  logic [DWL-1:0] fetchWord;
  logic           ldAccept;
  logic           ldDone;

  assign ldAccept  = (state == StLoad) && LdValid;
  assign ldDone    = ldAccept && (LdLast || (ldPtr == AWL'(DEPTH - 1)));
  // Upper PC bits are dropped so fetch wraps modulo DEPTH.
  assign fetchWord = imem[PCF[AWL-1:0]];

  // Memory contents survive reset; only the loader writes them.
  always_ff @(posedge CLK) begin
    if (!RST && ldAccept) begin
      imem[ldPtr] <= LdData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= StLoad;
      LdReady <= 1'b1;
      Running <= 1'b0;
      ldPtr   <= '0;
      PCF     <= '0;
      InstrD  <= '0;
      PCp1D   <= '0;
      ValidD  <= 1'b0;
    end else begin
      unique case (state)
        StLoad: begin
          if (ldAccept) begin
            ldPtr <= ldPtr + AWL'(1);
            if (ldDone) begin
              state   <= StRun;
              LdReady <= 1'b0;
              Running <= 1'b1;
            end
          end
        end
        StRun: begin
          // A stall also swallows any redirect; decode re-presents it afterwards.
          if (!Stall) begin
            if (JumpD) begin
              PCF    <= PCJumpD;
              InstrD <= '0;
              PCp1D  <= '0;
              ValidD <= 1'b0;
            end else if (PCSelD) begin
              PCF    <= PCBranchD;
              InstrD <= '0;
              PCp1D  <= '0;
              ValidD <= 1'b0;
            end else begin
              InstrD <= fetchWord;
              PCp1D  <= PCF + DWL'(1);
              ValidD <= 1'b1;
              PCF    <= PCF + DWL'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (state == StRun) begin
      if (Stall) begin
        StallCnt <= StallCnt + DWL'(1);
      end else if (JumpD || PCSelD) begin
        FlushCnt <= FlushCnt + DWL'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed loads and run-mode sequences, with a
// reference model pushing expected IF/ID state into a scoreboard popped after each edge.
module tb_fetch_stage;

  localparam int unsigned AWL   = 6;
  localparam int unsigned DWL   = 32;
  localparam int unsigned DEPTH = 64;

  logic        CLK = 1'b0;
  logic        RST, LdValid, LdLast, Stall, JumpD, PCSelD;
  logic        LdReady, Running, ValidD;
  logic [31:0] LdData, PCJumpD, PCBranchD, PCF, InstrD, PCp1D;
`ifdef FETCH_PERF_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  fetch_stage #(
    .AWL  (AWL),
    .DWL  (DWL),
    .DEPTH(DEPTH)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LdValid  (LdValid),
    .LdData   (LdData),
    .LdLast   (LdLast),
    .LdReady  (LdReady),
    .Running  (Running),
    .Stall    (Stall),
    .JumpD    (JumpD),
    .PCJumpD  (PCJumpD),
    .PCSelD   (PCSelD),
    .PCBranchD(PCBranchD),
    .PCF      (PCF),
    .InstrD   (InstrD),
    .PCp1D    (PCp1D),
    .ValidD   (ValidD)
`ifdef FETCH_PERF_EN
    ,
    .StallCnt (StallCnt),
    .FlushCnt (FlushCnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcp1;
    logic        valid;
  } expT;

  expT         sb[$];
  logic [31:0] mem [DEPTH];
  logic [31:0] mPc, mInstr, mPcp1, mStall, mFlush;
  logic        mValid, mRun;
  int          mPtr;
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag);
    expT e;
    e.tag   = tag;
    e.pcf   = mPc;
    e.instr = mInstr;
    e.pcp1  = mPcp1;
    e.valid = mValid;
    sb.push_back(e);
  endtask

  task automatic popCheck();
    expT e;
    if (sb.size() == 0) begin
      total++;
      failed++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_pcf"}, PCF, e.pcf);
      check({e.tag, "_instr"}, InstrD, e.instr);
      check({e.tag, "_pcp1"}, PCp1D, e.pcp1);
      check({e.tag, "_valid"}, 32'(ValidD), 32'(e.valid));
    end
  endtask

  task automatic checkPerf(input string tag);
`ifdef FETCH_PERF_EN
    check({tag, "_stallcnt"}, StallCnt, mStall);
    check({tag, "_flushcnt"}, FlushCnt, mFlush);
`else
    total = total + 0;
`endif
  endtask

  task automatic flushModel();
    mInstr = '0;
    mPcp1  = '0;
    mValid = 1'b0;
  endtask

  task automatic doReset(input string tag);
    LdValid = 1'b0;
    LdLast  = 1'b0;
    Stall   = 1'b0;
    JumpD   = 1'b0;
    PCSelD  = 1'b0;
    RST     = 1'b1;
    tick();
    RST    = 1'b0;
    mPc    = '0;
    mPtr   = 0;
    mRun   = 1'b0;
    mStall = '0;
    mFlush = '0;
    flushModel();
    pushExp(tag);
    popCheck();
    check({tag, "_ldready"}, 32'(LdReady), 32'd1);
    check({tag, "_running"}, 32'(Running), 32'd0);
    checkPerf(tag);
  endtask

  task automatic loadWord(input string tag, input logic [31:0] data, input logic last);
    check({tag, "_rdy_before"}, 32'(LdReady), 32'd1);
    LdValid = 1'b1;
    LdData  = data;
    LdLast  = last;
    tick();
    mem[mPtr] = data;
    if (last || mPtr == DEPTH - 1) mRun = 1'b1;
    mPtr++;
    LdValid = 1'b0;
    LdLast  = 1'b0;
    check({tag, "_running"}, 32'(Running), 32'(mRun));
    check({tag, "_ldready"}, 32'(LdReady), 32'(!mRun));
  endtask

  // Idle load cycle with run-mode controls asserted: none of them may act in LOAD.
  task automatic gap(input string tag);
    LdValid   = 1'b0;
    LdData    = $urandom;
    Stall     = 1'b1;
    JumpD     = 1'b1;
    PCJumpD   = 32'h15;
    tick();
    Stall     = 1'b0;
    JumpD     = 1'b0;
    check({tag, "_running"}, 32'(Running), 32'd0);
    pushExp(tag);
    popCheck();
    checkPerf(tag);
  endtask

  task automatic step(input string tag, input logic st, input logic j, input logic [31:0] pj,
                      input logic s, input logic [31:0] pb);
    Stall     = st;
    JumpD     = j;
    PCJumpD   = pj;
    PCSelD    = s;
    PCBranchD = pb;
    if (st) begin
      mStall++;
    end else if (j) begin
      mPc = pj;
      flushModel();
      mFlush++;
    end else if (s) begin
      mPc = pb;
      flushModel();
      mFlush++;
    end else begin
      mInstr = mem[mPc[5:0]];
      mPcp1  = mPc + 32'd1;
      mValid = 1'b1;
      mPc    = mPc + 32'd1;
    end
    pushExp(tag);
    tick();
    popCheck();
    Stall  = 1'b0;
    JumpD  = 1'b0;
    PCSelD = 1'b0;
  endtask

  // Run-mode loader traffic that the DUT must ignore.
  task automatic junkLoader();
    LdValid = 1'b1;
    LdData  = 32'hDEADBEEF;
    LdLast  = 1'b1;
  endtask

  initial begin
    RST = 1'b1; LdValid = 1'b0; LdData = '0; LdLast = 1'b0;
    Stall = 1'b0; JumpD = 1'b0; PCJumpD = '0; PCSelD = 1'b0; PCBranchD = '0;
    tick();
    doReset("rst0");

    // Full-depth load: RUN entered on the word at DEPTH-1 without LdLast.
    for (int i = 0; i < DEPTH; i++) loadWord("full", 32'h1000 + 32'(i), 1'b0);
    check("full_pcf", PCF, 32'd0);

    doReset("rst1");
    loadWord("ld11", 32'h11, 1'b0);
    loadWord("ld22", 32'h22, 1'b0);
    loadWord("ld33", 32'h33, 1'b0);
    loadWord("ld44", 32'h44, 1'b1);
    check("run_pcf0", PCF, 32'd0);
    junkLoader();
    step("f0", 0, 0, 0, 0, 0);
    check("f0_const", InstrD, 32'h11);
    step("f1", 0, 0, 0, 0, 0);
    step("f2", 0, 0, 0, 0, 0);
    step("f3", 0, 0, 0, 0, 0);
    check("f3_const", InstrD, 32'h44);
    check("f3_pcp1", PCp1D, 32'd4);

    // Stall at PCF=2, with redirects presented during the stall being ignored.
    step("jmp2", 0, 1, 32'd2, 0, 0);
    step("stall1", 1, 0, 0, 0, 0);
    step("stall2", 1, 1, 32'd7, 0, 0);
    step("stall3", 1, 0, 0, 1, 32'd9);
    step("resume", 0, 0, 0, 0, 0);
    check("resume_const", InstrD, 32'h33);

    step("jmp5", 0, 1, 32'd5, 0, 0);
    step("br20", 0, 0, 0, 1, 32'h20);
    check("br20_pcf", PCF, 32'h20);
    step("fetch32", 0, 0, 0, 0, 0);
    check("fetch32_const", InstrD, 32'h1020);
    step("br45", 0, 0, 0, 1, 32'h45);
    step("fetch45", 0, 0, 0, 0, 0);
    check("fetch45_const", InstrD, 32'h1005);

    step("jsel", 0, 1, 32'd9, 1, 32'd3);
    check("jsel_pcf", PCF, 32'd9);
    step("jselstall", 1, 1, 32'd11, 1, 32'd12);
    check("jselstall_pcf", PCF, 32'd9);

    step("jwrap", 0, 1, 32'hFFFF_FFFF, 0, 0);
    step("wrap", 0, 0, 0, 0, 0);
    check("wrap_pcp1", PCp1D, 32'd0);
    step("after_wrap", 0, 0, 0, 0, 0);
    step("after_wrap2", 0, 0, 0, 0, 0);
    checkPerf("run_end");

    // Mid-load reset, then reload restarting at address 0.
    doReset("rst2");
    loadWord("ma1", 32'hA1, 1'b0);
    gap("mgap");
    loadWord("ma2", 32'hA2, 1'b0);
    loadWord("ma3", 32'hA3, 1'b0);
    doReset("rst_mid");
    loadWord("aa", 32'hAA, 1'b1);
    junkLoader();
    step("faa", 0, 0, 0, 0, 0);
    check("faa_const", InstrD, 32'hAA);
    step("fa2", 0, 0, 0, 0, 0);

    // Gapped two-word load.
    doReset("rst3");
    loadWord("b1", 32'hB1, 1'b0);
    gap("bgap1");
    gap("bgap2");
    loadWord("b2", 32'hB2, 1'b1);
    check("b_pcf0", PCF, 32'd0);
    step("fb1", 0, 0, 0, 0, 0);
    step("fb2", 0, 0, 0, 0, 0);
    check("fb2_const", InstrD, 32'hB2);
    step("fa3", 0, 0, 0, 0, 0);
    check("fa3_const", InstrD, 32'hA3);
    step("stall_end", 1, 0, 0, 0, 0);
    checkPerf("end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
